// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between
// NUM_REQ valid/ready requesters, with a registered, ID-tagged response.
module alu_share_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 32,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]     req_op,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_opcode,
    input  logic [WIDTH-1:0]         alu_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [ID_W:0]   NREQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST   = ID_W'(NUM_REQ - 1);

    state_t             state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    rr_ptr_d;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic               rsp_valid_q;

    logic               found;
    logic [ID_W-1:0]    grant;
    logic [ID_W-1:0]    idx;
    logic [ID_W:0]      sum;

    // Scan from rr_ptr upward; first valid requester wins.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            idx = (sum >= NREQ_W) ? ID_W'(sum - NREQ_W) : ID_W'(sum);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    assign rr_ptr_d = (grant == LAST) ? '0 : grant + ID_W'(1);

    assign req_ready = (rst_n && state_q == IDLE && found)
                     ? (NUM_REQ'(1) << grant) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        a_q      <= req_a[grant*WIDTH +: WIDTH];
                        b_q      <= req_b[grant*WIDTH +: WIDTH];
                        op_q     <= req_op[grant*3 +: 3];
                        id_q     <= grant;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= alu_result;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_opcode = op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: cycle-level reference model plus directed
// transactions with hand-computed results.
module tb_alu_share_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*3-1:0] req_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [2:0]     alu_opcode;
    logic [W-1:0]   alu_result;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic [1:0]     rsp_id;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b011:  return {31'b0, a < b};
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_opcode);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk_eq(input string name, input logic [31:0] got,
                          input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    // Reference model: stage 0 = waiting, 1 = ALU busy, 2 = response held
    int           m_ptr, m_stage, m_id, m_rid, m_g;
    logic [W-1:0] m_a, m_b, m_data;
    logic [2:0]   m_op;

    function automatic int pick(input int ptr, input logic [N-1:0] v);
        logic [N-1:0] s;
        for (int k = 0; k < N; k++) begin
            s = v >> ((ptr + k) % N);
            if (s[0]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always_comb m_g = pick(m_ptr, req_valid);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stage <= 0; m_ptr <= 0; m_id <= 0; m_rid <= 0;
            m_a <= '0; m_b <= '0; m_op <= '0; m_data <= '0;
        end else begin
            case (m_stage)
                0: if (m_g >= 0) begin
                    m_a     <= req_a[m_g*W +: W];
                    m_b     <= req_b[m_g*W +: W];
                    m_op    <= req_op[m_g*3 +: 3];
                    m_id    <= m_g;
                    m_ptr   <= (m_g + 1) % N;
                    m_stage <= 1;
                end
                1: begin
                    m_data  <= alu_f(m_a, m_b, m_op);
                    m_rid   <= m_id;
                    m_stage <= 2;
                end
                2: if (rsp_ready) m_stage <= 0;
                default: m_stage <= 0;
            endcase
        end
    end

    initial begin
        logic [N-1:0] er;
        bit ok;
        forever begin
            @(negedge clk);
            er = (rst_n && m_stage == 0 && m_g >= 0) ? (4'(1) << m_g) : 4'b0;
            ok = (req_ready === er) && (rsp_valid === (m_stage == 2))
              && (rsp_data === m_data) && (rsp_id === 2'(m_rid))
              && (alu_a === m_a) && (alu_b === m_b) && (alu_opcode === m_op);
            n_checks++;
            if (ok) n_pass++;
            else $display("FAIL model t=%0t ready %b/%b vld %b/%0d data %h/%h id %0d/%0d alu %h,%h,%0d/%h,%h,%0d",
                          $time, req_ready, er, rsp_valid, m_stage == 2,
                          rsp_data, m_data, rsp_id, m_rid,
                          alu_a, alu_b, alu_opcode, m_a, m_b, m_op);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2:0] op);
        bit ok;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_op[i*3 +: 3] = op;
        req_valid[i] = 1'b1;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                ok = 1;
                break;
            end
        end
        chk_eq($sformatf("grant%0d", i), 32'(req_ready), 32'(4'(1) << i));
        step();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input logic [W-1:0] d,
                            input int id);
        int lat;
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        chk_eq({name, "_latency"}, 32'(lat), 32'd2);
        chk_eq({name, "_data"}, rsp_data, d);
        chk_eq({name, "_id"}, 32'(rsp_id), 32'(id));
    endtask

    initial begin
        int got;
        int ord[5] = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        @(negedge clk);
        chk_eq("reset_ready", 32'(req_ready), 32'd0);
        chk_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk_eq("reset_rsp_data", rsp_data, 32'd0);
        chk_eq("reset_rsp_id", 32'(rsp_id), 32'd0);
        #1 req_valid = '0;
        step();
        rst_n = 1'b1;
        step();

        send(0, 32'd5, 32'd7, 3'b000);
        wait_rsp("add", 32'd12, 0);
        step();
        send(1, 32'hFFFF_FFFF, 32'd1, 3'b000);
        wait_rsp("overflow", 32'd0, 1);
        step();
        send(2, 32'd3, 32'd9, 3'b011);
        wait_rsp("less_than", 32'd1, 2);
        step();

        // fairness from a fresh pointer
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 32'(i * 16 + 1);
            req_b[i*W +: W] = 32'(i);
            req_op[i*3 +: 3] = 3'b000;
        end
        req_valid = '1;
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                chk_eq($sformatf("fair_id%0d", got), 32'(rsp_id), 32'(ord[got]));
                chk_eq($sformatf("fair_data%0d", got), rsp_data,
                       32'(ord[got] * 17 + 1));
                got++;
            end
        end
        chk_eq("fair_count", 32'(got), 32'd5);
        step();
        req_valid = '0;
        step();

        rsp_ready = 1'b0;
        send(3, 32'd10, 32'd20, 3'b000);
        wait_rsp("bp", 32'd30, 3);
        #1 req_valid = '1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk_eq("bp_valid", 32'(rsp_valid), 32'd1);
            chk_eq("bp_data", rsp_data, 32'd30);
            chk_eq("bp_id", 32'(rsp_id), 32'd3);
            chk_eq("bp_ready", 32'(req_ready), 32'd0);
        end
        #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk_eq("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk_eq("bp_release_ready", 32'(req_ready), 32'd0);
        step();

        send(2, 32'd4, 32'd4, 3'b000);
        wait_rsp("pre_wrap", 32'd8, 2);
        step();
        send(1, 32'd100, 32'd50, 3'b011);
        wait_rsp("skip", 32'd0, 1);
        step();
        req_valid = '1;
        @(negedge clk);
        chk_eq("ptr_after_skip", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        wait_rsp("after_skip", 32'd8, 2);
        step();

        send(0, 32'd1, 32'd2, 3'b000);
        rst_n = 1'b0;
        @(negedge clk);
        chk_eq("exec_reset_valid", 32'(rsp_valid), 32'd0);
        chk_eq("exec_reset_ready", 32'(req_ready), 32'd0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk_eq("no_stale", 32'(rsp_valid), 32'd0);
        end
        step();
        req_valid = '1;
        @(negedge clk);
        chk_eq("ptr_after_reset", 32'(req_ready), 32'h1);
        #1 req_valid = '0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
